// File: rtl/fill_run_encoder.sv
// Run-length encoder for a word stream: all-zero / all-ones fill words collapse into
// (kind, count) tokens, anything else passes through as a one-word literal token.
module fill_run_encoder #(
    parameter int unsigned W  = 64,
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1:0]    out_kind,
    output logic [CW-1:0] out_count,
    output logic [W-1:0]  out_data,
    output logic          out_last
);

    localparam logic [1:0]    KLit   = 2'd0;
    localparam logic [1:0]    KFill0 = 2'd1;
    localparam logic [1:0]    KFill1 = 2'd2;
    localparam logic [CW-1:0] MaxRun = {CW{1'b1}};

    typedef enum logic [1:0] {StIdle, StAcc, StFlush} state_e;

    state_e        state_q, state_d;
    logic [1:0]    kind_q, kind_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  hold_data_q, hold_data_d;
    logic          hold_last_q, hold_last_d;

    logic          out_valid_q, out_valid_d;
    logic [1:0]    out_kind_q, out_kind_d;
    logic [CW-1:0] out_count_q, out_count_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          out_last_q, out_last_d;

    logic          slot_free, accept;
    logic [1:0]    in_kind, proc_kind, emit_kind;
    logic          proc_en, proc_last, emit, emit_last;
    logic [W-1:0]  proc_data;
    logic [CW-1:0] emit_cnt;

    function automatic logic [1:0] classify(input logic [W-1:0] d);
        if (d == '0) return KFill0;
        if (d == '1) return KFill1;
        return KLit;
    endfunction

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = (state_q != StFlush) && slot_free;
    assign accept    = in_valid && in_ready;
    assign in_kind   = classify(in_data);

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        cnt_d       = cnt_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        proc_en     = 1'b0;
        proc_data   = in_data;
        proc_last   = in_last;
        emit        = 1'b0;
        emit_kind   = kind_q;
        emit_cnt    = cnt_q;
        emit_last   = 1'b0;

        case (state_q)
            StIdle: proc_en = accept;
            StAcc: begin
                if (accept) begin
                    if (in_kind == kind_q) begin
                        if (!in_last && cnt_q < MaxRun - CW'(1)) begin
                            cnt_d = cnt_q + CW'(1);
                        end else begin
                            emit      = 1'b1;
                            emit_cnt  = cnt_q + CW'(1);
                            emit_last = in_last;
                            state_d   = StIdle;
                            cnt_d     = '0;
                        end
                    end else begin
                        // Close the run now; the mismatching word is replayed from hold
                        emit        = 1'b1;
                        hold_data_d = in_data;
                        hold_last_d = in_last;
                        state_d     = StFlush;
                    end
                end
            end
            StFlush: begin
                if (slot_free) begin
                    proc_en   = 1'b1;
                    proc_data = hold_data_q;
                    proc_last = hold_last_q;
                end
            end
            default: state_d = StIdle;
        endcase

        proc_kind = classify(proc_data);
        if (proc_en) begin
            state_d = StIdle;
            cnt_d   = '0;
            if (proc_kind == KLit || proc_last) begin
                emit      = 1'b1;
                emit_kind = proc_kind;
                emit_cnt  = CW'(1);
                emit_last = proc_last;
            end else begin
                state_d = StAcc;
                kind_d  = proc_kind;
                cnt_d   = CW'(1);
            end
        end

        out_valid_d = out_valid_q;
        out_kind_d  = out_kind_q;
        out_count_d = out_count_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (slot_free) out_valid_d = 1'b0;
        // emit is only ever raised while the slot is free
        if (emit) begin
            out_valid_d = 1'b1;
            out_kind_d  = emit_kind;
            out_count_d = emit_cnt;
            out_data_d  = (emit_kind == KLit) ? proc_data : {W{emit_kind == KFill1}};
            out_last_d  = emit_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            kind_q      <= '0;
            cnt_q       <= '0;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_kind_q  <= '0;
            out_count_q <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            cnt_q       <= cnt_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
            out_valid_q <= out_valid_d;
            out_kind_q  <= out_kind_d;
            out_count_q <= out_count_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_kind  = out_kind_q;
    assign out_count = out_count_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_fill_run_encoder.sv
// Scoreboard bench for fill_run_encoder: expected tokens come from a batch
// run-splitting model of each frame and are matched in order as tokens leave.
module tb_fill_run_encoder;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_last;
    logic [63:0] in_data;
    logic        out_valid, out_ready, out_last;
    logic [1:0]  out_kind;
    logic [3:0]  out_count;
    logic [63:0] out_data;

    int n_checks = 0;
    int n_err    = 0;
    int stall_cnt;
    bit rdy_rand  = 1'b0;
    bit rdy_force = 1'b1;

    logic [70:0] exp_q[$];
    logic [63:0] frm[$];

    fill_run_encoder #(.W(64), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_count(out_count), .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, expv);
        end
    endtask

    function automatic int cls(input logic [63:0] d);
        if (d == 64'h0) return 1;
        if (d == ONES) return 2;
        return 0;
    endfunction

    // Greedy split: literals alone, fill runs chopped into chunks of at most 15
    task automatic build_expect();
        int i = 0;
        int n = frm.size();
        while (i < n) begin
            int k = cls(frm[i]);
            if (k == 0) begin
                exp_q.push_back({2'd0, 4'd1, frm[i], i == n - 1});
                i++;
            end else begin
                int j = i;
                while (j < n && cls(frm[j]) == k && j - i < 15) j++;
                exp_q.push_back({2'(k), 4'(j - i), (k == 2) ? ONES : 64'h0, j == n});
                i = j;
            end
        end
    endtask

    task automatic send_word(input logic [63:0] d, input logic l, input bit gaps);
        bit acc = 1'b0;
        int n = 0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < frm.size(); i++) send_word(frm[i], i == frm.size() - 1, gaps);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // out_ready updates at posedge+2 so the driver's posedge+1 changes settle first
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    always @(negedge clk) begin
        if (rst_n && in_valid && !in_ready) stall_cnt++;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_token", {out_kind, out_count, out_data, out_last}, 0);
            end else begin
                check("token", {out_kind, out_count, out_data, out_last}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [70:0] snap;
        int bad;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Reset in the middle of a fill run: nothing from the lost run may appear
        for (int i = 0; i < 3; i++) send_word(64'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrun_rst_out_valid", out_valid, 0);
        check("midrun_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        frm = {ONES};
        build_expect();
        send_frame(1'b0);
        drain();

        // Kind change costs exactly one bubble
        frm = {64'h0, 64'h0, 64'h0, 64'h0, 64'h0, ONES, ONES, ONES};
        build_expect();
        stall_cnt = 0;
        send_frame(1'b0);
        check("kind_change_bubble", stall_cnt, 1);
        drain();

        frm = {};
        for (int i = 0; i < 20; i++) frm.push_back(ONES);
        build_expect();
        send_frame(1'b0);
        drain();

        frm = {64'h7, 64'h0, 64'h1};
        build_expect();
        send_word(64'h7, 1'b0, 1'b0);
        check("lit_latency", {out_valid, out_kind, out_data}, {1'b1, 2'd0, 64'h7});
        send_word(64'h0, 1'b0, 1'b0);
        send_word(64'h1, 1'b1, 1'b0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain();

        // Backpressure across a run change: outputs frozen, input blocked
        rdy_force = 1'b0;
        @(posedge clk); #3;
        frm = {64'h0, 64'h0, 64'h0, 64'h0, ONES, ONES};
        build_expect();
        for (int i = 0; i < 5; i++) send_word(frm[i], 1'b0, 1'b0);
        in_valid = 1'b1; in_data = ONES; in_last = 1'b1;
        snap = {out_kind, out_count, out_data, out_last};
        check("stall_out_valid", out_valid, 1);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if ({out_kind, out_count, out_data, out_last} !== snap || !out_valid || in_ready)
                bad++;
        end
        check("stall_hold", bad, 0);
        @(posedge clk); #1;
        rdy_force = 1'b1;
        send_word(ONES, 1'b1, 1'b0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain();

        // Random frames with random backpressure and input gaps
        rdy_rand = 1'b1;
        for (int f = 0; f < 40; f++) begin
            frm = {};
            for (int s = 0; s < $urandom_range(1, 5); s++) begin
                int r = $urandom_range(0, 9);
                int len = $urandom_range(1, 20);
                if (r < 4) for (int i = 0; i < len; i++) frm.push_back(64'h0);
                else if (r < 8) for (int i = 0; i < len; i++) frm.push_back(ONES);
                else if (r == 8) frm.push_back({$urandom, $urandom});
                else frm.push_back(64'(1) << $urandom_range(0, 63));
            end
            build_expect();
            send_frame(1'b1);
        end
        drain();
        rdy_rand = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
